branch_perf_counter: RTL

//  - In-design branch-prediction performance counter unit; reads the branch commit events that the processor raises.
//  - Counts cycles, committed branches, wrong-taken mispredicts and wrong-not-taken jump triggers.
//  - Software reads the counts through a small memory-mapped register port, so figures exist outside simulation.
//  - Sits beside the processor, taps the MEM-stage branch strobes, and is decoded into the data-memory address map.

---
 rtl/branch_perf_counter_pkg.sv | 30 +++
 rtl/branch_perf_counter_if.sv | 23 ++
 rtl/branch_perf_counter_event.sv | 55 +++++
 rtl/branch_perf_counter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/branch_perf_counter_pkg.sv
// Shared definitions for the branch performance counter: register map,
// CTRL bit positions and the RUN/FROZEN state encoding.
package branch_perf_counter_pkg;

    localparam logic [7:0] BPC_CYC_LO    = 8'h00;
    localparam logic [7:0] BPC_CYC_HI    = 8'h04;
    localparam logic [7:0] BPC_BR_COMMIT = 8'h08;
    localparam logic [7:0] BPC_MISPRED   = 8'h0C;
    localparam logic [7:0] BPC_MISJUMP   = 8'h10;
    localparam logic [7:0] BPC_CTRL      = 8'h14;

    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_FREEZE_BIT = 1;
    localparam int CTRL_SAT_BIT    = 2;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } bpc_state_e;

    // CTRL readback: clear is self-clearing and always reads 0
    function automatic logic [31:0] ctrl_word(input logic frozen, input logic sat);
        logic [31:0] w_word;
        w_word                  = '0;
        w_word[CTRL_FREEZE_BIT] = frozen;
        w_word[CTRL_SAT_BIT]    = sat;
        return w_word;
    endfunction

endpackage

// File: rtl/branch_perf_counter_if.sv
// Memory-mapped register port of the branch performance counter:
// one-cycle-latency read channel and a single-cycle write strobe.
interface branch_perf_counter_if #(
    parameter int ADDR_W = 5
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/branch_perf_counter_event.sv
// Single event counter with synchronous clear and hold; wraps by default,
// sticks at all-ones with a sticky flag when PERF_SATURATE_EN is defined.
module perf_event_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    input  logic             i_hold,
    output logic [CNT_W-1:0] o_count,
    output logic             o_sat
);

    logic [CNT_W-1:0] r_count;

`ifdef PERF_SATURATE_EN
    logic r_sat;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (i_clr) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (i_inc && !i_hold) begin
            if (&r_count) begin
                r_sat <= 1'b1;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_sat = r_sat;
`else
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !i_hold) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_sat = 1'b0;
`endif

    assign o_count = r_count;

endmodule

// File: rtl/branch_perf_counter.sv
// Branch-prediction performance counter: 64-bit cycle counter plus three event
// counters behind a register port. Optional macro: PERF_SATURATE_EN.
module branch_perf_counter
    import branch_perf_counter_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  commit_branch,
    input  logic                  mispredict,
    input  logic                  branch_jump_trigger,
    branch_perf_counter_if.slave  bus,
    output logic                  frozen
);

    localparam logic [ADDR_W-1:0] A_CYC_LO    = ADDR_W'(BPC_CYC_LO);
    localparam logic [ADDR_W-1:0] A_CYC_HI    = ADDR_W'(BPC_CYC_HI);
    localparam logic [ADDR_W-1:0] A_BR_COMMIT = ADDR_W'(BPC_BR_COMMIT);
    localparam logic [ADDR_W-1:0] A_MISPRED   = ADDR_W'(BPC_MISPRED);
    localparam logic [ADDR_W-1:0] A_MISJUMP   = ADDR_W'(BPC_MISJUMP);
    localparam logic [ADDR_W-1:0] A_CTRL      = ADDR_W'(BPC_CTRL);

    bpc_state_e       r_state;
    bpc_state_e       w_state_next;
    logic [63:0]      r_cycle;
    logic [31:0]      r_shadow_hi;
    logic [31:0]      r_rd_data;
    logic             r_rd_valid;
    logic [31:0]      w_rd_mux;
    logic             w_ctrl_wr;
    logic             w_clear;
    logic             w_hold;
    logic [CNT_W-1:0] w_br_count;
    logic [CNT_W-1:0] w_mis_count;
    logic [CNT_W-1:0] w_jmp_count;
    logic             w_br_sat;
    logic             w_mis_sat;
    logic             w_jmp_sat;
    logic             w_any_sat;
    logic             w_unused_wr_data;

    assign w_ctrl_wr        = bus.wr_en && (bus.wr_addr == A_CTRL);
    assign w_clear          = w_ctrl_wr && bus.wr_data[CTRL_CLEAR_BIT];
    assign w_hold           = (r_state == ST_FROZEN);
    assign w_any_sat        = w_br_sat | w_mis_sat | w_jmp_sat;
    assign w_unused_wr_data = ^bus.wr_data[31:CTRL_SAT_BIT];
    assign frozen           = w_hold;

    // A CTRL write always reloads the freeze state from bit1, whatever bit0 says
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_state_next = r_state;
        if (w_ctrl_wr) begin
            w_state_next = bus.wr_data[CTRL_FREEZE_BIT] ? ST_FROZEN : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle <= '0;
        end else if (w_clear) begin
            r_cycle <= '0;
        end else if (!w_hold) begin
            r_cycle <= r_cycle + 64'd1;
        end
    end

    perf_event_counter #(.CNT_W(CNT_W)) u_br_commit (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (commit_branch),
        .i_clr   (w_clear),
        .i_hold  (w_hold),
        .o_count (w_br_count),
        .o_sat   (w_br_sat)
    );

    perf_event_counter #(.CNT_W(CNT_W)) u_mispred (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (commit_branch & mispredict),
        .i_clr   (w_clear),
        .i_hold  (w_hold),
        .o_count (w_mis_count),
        .o_sat   (w_mis_sat)
    );

    perf_event_counter #(.CNT_W(CNT_W)) u_misjump (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (commit_branch & branch_jump_trigger),
        .i_clr   (w_clear),
        .i_hold  (w_hold),
        .o_count (w_jmp_count),
        .o_sat   (w_jmp_sat)
    );

    // Read mux sees pre-edge state, so same-cycle clear/write cannot affect it
    always_comb begin
        w_rd_mux = '0;
        case (bus.rd_addr)
            A_CYC_LO:    w_rd_mux = r_cycle[31:0];
            A_CYC_HI:    w_rd_mux = r_shadow_hi;
            A_BR_COMMIT: w_rd_mux = 32'(w_br_count);
            A_MISPRED:   w_rd_mux = 32'(w_mis_count);
            A_MISJUMP:   w_rd_mux = 32'(w_jmp_count);
            A_CTRL:      w_rd_mux = ctrl_word(w_hold, w_any_sat);
            default:     w_rd_mux = '0;
        endcase
    end

    // Reading CYC_LO snapshots the upper half so a following CYC_HI read is coherent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_shadow_hi <= '0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_data <= w_rd_mux;
                if (bus.rd_addr == A_CYC_LO) begin
                    r_shadow_hi <= r_cycle[63:32];
                end
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;

endmodule
